serial_add_arbiter: RTL

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin arbiter sharing one bit-serial full-adder slice.
// The winner's operands are latched on the grant edge and added LSB first,
// one bit per clock. The final carry lands in result[WIDTH], followed by a
// one-cycle done pulse to the owner.
module serial_add_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a_in0,
  input  logic [WIDTH-1:0] b_in0,
  input  logic [WIDTH-1:0] a_in1,
  input  logic [WIDTH-1:0] b_in1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH:0]   result
);

  localparam int unsigned IW = $clog2(WIDTH) + 1;
  // Index value at which all WIDTH sum bits have been produced
  localparam logic [IW-1:0] IdxLast = IW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  // Requester favoured when both request at once
  logic             rr_q, rr_d;

  logic winner;
  logic a_bit, b_bit, sum_bit, carry_bit;

  // Arbitration: a sole requester wins, a tie goes to the favoured requester
  always_comb begin
    winner = (req == 2'b11) ? rr_q : req[1];
  end

  // Shared full-adder slice fed by the operand bits at the current index
  always_comb begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (idx_q == IW'(i)) begin
        a_bit = a_q[i];
        b_bit = b_q[i];
      end
    end
    sum_bit   = a_bit ^ b_bit ^ carry_q;
    carry_bit = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    rr_d     = rr_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d    = winner ? 2'b10 : 2'b01;
          a_d      = winner ? a_in1 : a_in0;
          b_d      = winner ? b_in1 : b_in0;
          rr_d     = ~winner;
          carry_d  = 1'b0;
          idx_d    = '0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (idx_q == IdxLast) begin
          result_d[WIDTH] = carry_q;
          state_d         = StDone;
        end else begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (idx_q == IW'(i)) begin
              result_d[i] = sum_bit;
            end
          end
          carry_d = carry_bit;
          idx_d   = idx_q + 1'b1;
        end
      end
      StDone: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= 2'b00;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rr_q     <= rr_d;
    end
  end

  // Outputs: done mirrors the grant only during the single DONE cycle
  always_comb begin
    gnt    = gnt_q;
    busy   = (state_q != StIdle);
    done   = (state_q == StDone) ? gnt_q : 2'b00;
    result = result_q;
  end

endmodule
